updown_counter: RTL and testbench

Parametrised successor to the fixed 8-bit free-running counter. Generalised in width and count range, with runtime direction, enable, synchronous clear and parallel load. Terminal behaviour is selectable: wrap-around or saturate. Serves as the common counting primitive for timers, address generators and event counters, and carries its own embedded assertions.

---
 rtl/updown_counter.sv | 116 +++++++++++
 tb/tb_updown_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Parametrised up/down counter with range bounds, clear, clamped load and wrap/saturate terminal handling.
// Embedded assertions and covers check stepping, range, reset and terminal-pulse behaviour.
module updown_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MIN_VAL  = 0,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RST_VAL  = 0,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             term
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_badWidth
      $error("updown_counter: WIDTH must be 1..32");
    end
    if (!(MIN_VAL < MAX_VAL) || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_badRange
      $error("updown_counter: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_badRst
      $error("updown_counter: RST_VAL outside [MIN_VAL, MAX_VAL]");
    end
  endgenerate

  localparam logic [WIDTH:0]   C_MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   C_MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   C_RST_X = (WIDTH+1)'(RST_VAL);
  localparam logic [WIDTH:0]   C_ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] C_MIN   = C_MIN_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_MAX   = C_MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_RST   = C_RST_X[WIDTH-1:0];

  logic [WIDTH-1:0] r_cnt;
  logic             r_term;

  logic [WIDTH:0]   w_cntX;
  logic [WIDTH:0]   w_lvX;
  logic [WIDTH:0]   w_nextX;
  logic             w_nextTerm;
  logic             w_atMax;
  logic             w_atMin;
  logic             w_lvAbove;
  logic             w_lvBelow;
  logic             w_stepEvt;
  logic             w_termEvt;

  assign w_cntX    = {1'b0, r_cnt};
  assign w_lvX     = {1'b0, load_val};
  assign w_atMax   = (r_cnt == C_MAX);
  assign w_atMin   = (r_cnt == C_MIN);
  // The +1 form keeps the below-minimum test meaningful when MIN_VAL is zero.
  assign w_lvAbove = (w_lvX > C_MAX_X);
  assign w_lvBelow = ((w_lvX + C_ONE_X) <= C_MIN_X);
  assign w_termEvt = en && !clr && !load && (dir ? w_atMax : w_atMin);
  assign w_stepEvt = en && !clr && !load && !(dir ? w_atMax : w_atMin);

  always_comb begin
    w_nextX    = w_cntX;
    w_nextTerm = 1'b0;
    if (clr) begin
      w_nextX = C_RST_X;
    end else if (load) begin
      if (w_lvAbove)      w_nextX = C_MAX_X;
      else if (w_lvBelow) w_nextX = C_MIN_X;
      else                w_nextX = w_lvX;
    end else if (en) begin
      if (w_termEvt) begin
        w_nextTerm = 1'b1;
        if (!SATURATE) w_nextX = dir ? C_MIN_X : C_MAX_X;
      end else begin
        w_nextX = dir ? (w_cntX + C_ONE_X) : (w_cntX - C_ONE_X);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= C_RST;
      r_term <= 1'b0;
    end else begin
      r_cnt  <= w_nextX[WIDTH-1:0];
      r_term <= w_nextTerm;
    end
  end

  assign cnt    = r_cnt;
  assign term   = r_term;
  assign at_max = w_atMax;
  assign at_min = w_atMin;

  a_step: assert property (@(posedge clk) disable iff (!rst_n)
    w_stepEvt |=> cnt == ($past(dir) ? WIDTH'($past(cnt) + 1'b1) : WIDTH'($past(cnt) - 1'b1)));
  // The carry bit of the next-state word must never be set, i.e. nothing escapes the range.
  a_range: assert property (@(posedge clk) disable iff (!rst_n)
    ((w_cntX + C_ONE_X) > C_MIN_X) && (w_cntX <= C_MAX_X) && !w_nextX[WIDTH]);
  a_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(cnt));
  a_reset: assert property (@(posedge clk) !rst_n |=> cnt == C_RST);
  a_term:  assert property (@(posedge clk) disable iff (!rst_n) term |-> $past(w_termEvt));

  c_step:  cover property (@(posedge clk) disable iff (!rst_n) w_stepEvt);
  c_range: cover property (@(posedge clk) disable iff (!rst_n) w_atMax || w_atMin);
  c_known: cover property (@(posedge clk) disable iff (!rst_n) !$isunknown(cnt));
  c_reset: cover property (@(posedge clk) !rst_n ##1 rst_n);
  c_term:  cover property (@(posedge clk) disable iff (!rst_n) term);

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: four differently parametrised instances driven from a vector table,
// with expectations queued at drive time and popped once the DUT has clocked.
module tb_updown_counter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      en, dir, clr, load;
  logic [3:0][7:0] lv;
  logic [3:0][7:0] cnt;
  logic [3:0]      atMax, atMin, term;

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    int         inst;
    logic       e, d, c, l;
    logic [7:0] v;
    logic [7:0] expCnt;
    logic       expTerm, expMax, expMin;
    string      name;
  } vec_t;

  typedef struct {
    int         inst;
    logic [7:0] cnt;
    logic       term, mx, mn;
    string      name;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  // u0: defaults; u1: 3..10 wrap from 5; u2: 0..10 saturate; u3: 3..100 wrap from 5
  updown_counter #(.WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .dir(dir[0]), .clr(clr[0]), .load(load[0]),
    .load_val(lv[0]), .cnt(cnt[0]), .at_max(atMax[0]), .at_min(atMin[0]), .term(term[0]));
  updown_counter #(.WIDTH(8), .MIN_VAL(3), .MAX_VAL(10), .RST_VAL(5), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .dir(dir[1]), .clr(clr[1]), .load(load[1]),
    .load_val(lv[1]), .cnt(cnt[1]), .at_max(atMax[1]), .at_min(atMin[1]), .term(term[1]));
  updown_counter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(10), .RST_VAL(0), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .dir(dir[2]), .clr(clr[2]), .load(load[2]),
    .load_val(lv[2]), .cnt(cnt[2]), .at_max(atMax[2]), .at_min(atMin[2]), .term(term[2]));
  updown_counter #(.WIDTH(8), .MIN_VAL(3), .MAX_VAL(100), .RST_VAL(5), .SATURATE(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en[3]), .dir(dir[3]), .clr(clr[3]), .load(load[3]),
    .load_val(lv[3]), .cnt(cnt[3]), .at_max(atMax[3]), .at_min(atMin[3]), .term(term[3]));

  task automatic expectNow(input int inst, input logic [7:0] c, input logic t,
                           input logic mx, input logic mn, input string name);
    exp_t e;
    e.inst = inst; e.cnt = c; e.term = t; e.mx = mx; e.mn = mn; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      nVec++;
      if (cnt[e.inst] !== e.cnt || term[e.inst] !== e.term ||
          atMax[e.inst] !== e.mx || atMin[e.inst] !== e.mn) begin
        nMis++;
        $display("[TB] FAIL %s u%0d: got cnt=%0d term=%b at_max=%b at_min=%b, want cnt=%0d term=%b at_max=%b at_min=%b",
                 e.name, e.inst, cnt[e.inst], term[e.inst], atMax[e.inst], atMin[e.inst],
                 e.cnt, e.term, e.mx, e.mn);
      end
    end
  endtask

  task automatic idleInputs();
    en = '0; dir = '0; clr = '0; load = '0; lv = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    idleInputs();
    en[v.inst] = v.e; dir[v.inst] = v.d; clr[v.inst] = v.c; load[v.inst] = v.l; lv[v.inst] = v.v;
    expectNow(v.inst, v.expCnt, v.expTerm, v.expMax, v.expMin, v.name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic vec_t mk(int inst, logic e, logic d, logic c, logic l, logic [7:0] v,
                              logic [7:0] ec, logic et, logic emx, logic emn, string name);
    vec_t r;
    r.inst = inst; r.e = e; r.d = d; r.c = c; r.l = l; r.v = v;
    r.expCnt = ec; r.expTerm = et; r.expMax = emx; r.expMin = emn; r.name = name;
    return r;
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   8'd4,   0, 0, 0, "down_5to4"));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   8'd3,   0, 0, 1, "down_to_min"));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   8'd10,  1, 1, 0, "wrap_min_to_max"));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'd0,   8'd9,   0, 0, 0, "after_wrap"));
    tbl.push_back(mk(1, 0, 0, 1, 0, 8'd0,   8'd5,   0, 0, 0, "clr_to_rst"));
    tbl.push_back(mk(2, 0, 0, 0, 1, 8'd8,   8'd8,   0, 0, 0, "sat_load8"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'd0,   8'd9,   0, 0, 0, "sat_up9"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'd0,   8'd10,  0, 1, 0, "sat_up10"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'd0,   8'd10,  1, 1, 0, "sat_hold1"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'd0,   8'd10,  1, 1, 0, "sat_hold2"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 8'd0,   8'd10,  1, 1, 0, "sat_hold3"));
    tbl.push_back(mk(2, 0, 1, 0, 0, 8'd0,   8'd10,  0, 1, 0, "sat_idle"));
    tbl.push_back(mk(2, 1, 0, 0, 0, 8'd0,   8'd9,   0, 0, 0, "sat_down"));
    tbl.push_back(mk(3, 0, 0, 0, 1, 8'd200, 8'd100, 0, 1, 0, "load_clamp_hi"));
    tbl.push_back(mk(3, 0, 0, 0, 1, 8'd1,   8'd3,   0, 0, 1, "load_clamp_lo"));
    tbl.push_back(mk(3, 1, 1, 1, 1, 8'd50,  8'd5,   0, 0, 0, "clr_beats_all"));
    tbl.push_back(mk(3, 1, 1, 0, 1, 8'd7,   8'd7,   0, 0, 0, "load_beats_en"));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'd0,   8'd8,   0, 0, 0, "up_after_load"));
    tbl.push_back(mk(3, 1, 0, 0, 0, 8'd0,   8'd7,   0, 0, 0, "dir_flip"));
    tbl.push_back(mk(3, 0, 0, 0, 1, 8'd3,   8'd3,   0, 0, 1, "load_min"));
    tbl.push_back(mk(3, 1, 0, 0, 0, 8'd0,   8'd100, 1, 1, 0, "wrap_down"));
    tbl.push_back(mk(3, 1, 1, 0, 0, 8'd0,   8'd3,   1, 0, 1, "wrap_up"));

    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expectNow(0, 8'd0, 0, 0, 1, "reset_u0");
    expectNow(1, 8'd5, 0, 0, 0, "reset_u1");
    expectNow(2, 8'd0, 0, 0, 1, "reset_u2");
    expectNow(3, 8'd5, 0, 0, 0, "reset_u3");
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    // Full 8-bit sweep with one wrap: the term pulse lands on the step after 255.
    for (int k = 1; k <= 257; k++) begin
      logic [7:0] c;
      c = 8'(k % 256);
      applyStimulus(mk(0, 1, 1, 0, 0, 8'd0, c, (k == 256), (c == 8'd255), (c == 8'd0), "sweep"));
    end

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    applyStimulus(mk(0, 0, 0, 0, 1, 8'd41, 8'd41, 0, 0, 0, "pre_rst_load"));
    applyStimulus(mk(0, 1, 1, 0, 0, 8'd0,  8'd42, 0, 0, 0, "pre_rst_42"));

    // Reset between edges while counting, then release between edges with en still high.
    @(negedge clk);
    idleInputs();
    en[0] = 1'b1; dir[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expectNow(0, 8'd0, 0, 0, 1, "async_rst_u0");
    expectNow(3, 8'd5, 0, 0, 0, "async_rst_u3");
    checkOutput();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectNow(0, 8'd1, 0, 0, 0, "resume_1");
    checkOutput();
    @(posedge clk);
    #1;
    expectNow(0, 8'd2, 0, 0, 0, "resume_2");
    checkOutput();

    @(negedge clk);
    idleInputs();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
